avmm_regfile_bridge: RTL and testbench

//  Avalon-MM slave front end for the byte-enabled control/status register file.

---
 rtl/avmm_regfile_bridge.sv | 105 ++++++++++
 tb/tb_avmm_regfile_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/avmm_regfile_bridge.sv
// avmm_regfile_bridge: Avalon-MM slave that turns single-word reads/writes into register-file strobes
// Optional statistics counters: define AVMM_REGFILE_BRIDGE_STATS_EN
// Ports:
//   clk_i, rst_i (async, active-high)
//   avs_address_i/read_i/write_i/writedata_i/byteenable_i  Avalon request
//   avs_waitrequest_o, avs_readdata_o, avs_readdatavalid_o   Avalon response
//   rf_addr_o, rf_wren_o, rf_be_o, rf_data_o                 register-file strobes (registered)
//   rf_data_i                                                register-file combinational read data
//   proto_err_o                                              sticky read+write collision flag
//   stats_clr_i, wr_cnt_o, rd_cnt_o                          statistics (STATS_EN only)
module avmm_regfile_bridge #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   avs_address_i,
  input  logic                avs_read_i,
  input  logic                avs_write_i,
  input  logic [DATA_W-1:0]   avs_writedata_i,
  input  logic [DATA_W/8-1:0] avs_byteenable_i,
  output logic                avs_waitrequest_o,
  output logic [DATA_W-1:0]   avs_readdata_o,
  output logic                avs_readdatavalid_o,
  output logic [ADDR_W-1:0]   rf_addr_o,
  output logic                rf_wren_o,
  output logic [DATA_W/8-1:0] rf_be_o,
  output logic [DATA_W-1:0]   rf_data_o,
  input  logic [DATA_W-1:0]   rf_data_i,
  output logic                proto_err_o
`ifdef AVMM_REGFILE_BRIDGE_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [CNT_W-1:0]    wr_cnt_o,
  output logic [CNT_W-1:0]    rd_cnt_o
`endif
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   data_q, rdata_q;
  logic                err_q;
  logic                accept;
  assign accept = (state_q == IDLE) & (avs_read_i | avs_write_i);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (avs_write_i ? WR : RD) : IDLE;
      WR:      state_d = IDLE;
      RD:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= avs_address_i;
        be_q   <= avs_byteenable_i;
        data_q <= avs_writedata_i;
      end
      if (state_q == RD) rdata_q <= rf_data_i;
      if (accept & avs_read_i & avs_write_i) err_q <= 1'b1;
    end
  end
  assign avs_waitrequest_o   = rst_i | (state_q != IDLE);
  assign avs_readdatavalid_o = state_q == RESP;
  assign avs_readdata_o      = rdata_q;
  // a zero byte-enable write is dropped by never raising the strobe
  assign rf_wren_o           = (state_q == WR) & (|be_q);
  assign rf_addr_o           = addr_q;
  assign rf_be_o             = be_q;
  assign rf_data_o           = data_q;
  assign proto_err_o         = err_q;
`ifdef AVMM_REGFILE_BRIDGE_STATS_EN
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  always_comb begin
    wr_cnt_d = stats_clr_i ? '0 : (accept & avs_write_i & ~&wr_cnt_q) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d = stats_clr_i ? '0 : (avs_readdatavalid_o & ~&rd_cnt_q) ? rd_cnt_q + 1'b1 : rd_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_avmm_regfile_bridge.sv
// tb_avmm_regfile_bridge: directed self-checking bench for avmm_regfile_bridge
module tb_avmm_regfile_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [6:0]  avs_address_i = '0;
  logic        avs_read_i = 1'b0;
  logic        avs_write_i = 1'b0;
  logic [15:0] avs_writedata_i = '0;
  logic [1:0]  avs_byteenable_i = '0;
  logic        avs_waitrequest_o;
  logic [15:0] avs_readdata_o;
  logic        avs_readdatavalid_o;
  logic [6:0]  rf_addr_o;
  logic        rf_wren_o;
  logic [1:0]  rf_be_o;
  logic [15:0] rf_data_o;
  logic [15:0] rf_data_i = '0;
  logic        proto_err_o;
  int          checks = 0;
  int          failures = 0;
`ifdef AVMM_REGFILE_BRIDGE_STATS_EN
  logic        stats_clr_i = 1'b0;
  logic [1:0]  wr_cnt_o, rd_cnt_o;
  avmm_regfile_bridge #(.ADDR_W(7), .DATA_W(16), .CNT_W(2)) dut (
`else
  avmm_regfile_bridge #(.ADDR_W(7), .DATA_W(16)) dut (
`endif
    .clk_i(clk_i), .rst_i(rst_i),
    .avs_address_i(avs_address_i), .avs_read_i(avs_read_i), .avs_write_i(avs_write_i),
    .avs_writedata_i(avs_writedata_i), .avs_byteenable_i(avs_byteenable_i),
    .avs_waitrequest_o(avs_waitrequest_o), .avs_readdata_o(avs_readdata_o),
    .avs_readdatavalid_o(avs_readdatavalid_o),
    .rf_addr_o(rf_addr_o), .rf_wren_o(rf_wren_o), .rf_be_o(rf_be_o), .rf_data_o(rf_data_o),
    .rf_data_i(rf_data_i), .proto_err_o(proto_err_o)
`ifdef AVMM_REGFILE_BRIDGE_STATS_EN
    , .stats_clr_i(stats_clr_i), .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic rd, input logic wr, input logic [6:0] a, input logic [15:0] d, input logic [1:0] be);
    avs_read_i = rd;
    avs_write_i = wr;
    avs_address_i = a;
    avs_writedata_i = d;
    avs_byteenable_i = be;
  endtask
  task automatic idle_bus();
    avs_read_i = 1'b0;
    avs_write_i = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_waitreq", avs_waitrequest_o, 1);
    chk("rst_wren", rf_wren_o, 0);
    chk("rst_rvalid", avs_readdatavalid_o, 0);
    chk("rst_addr", rf_addr_o, 0);
    chk("rst_rdata", avs_readdata_o, 0);
    chk("rst_perr", proto_err_o, 0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("idle_waitreq", avs_waitrequest_o, 0);
    req(0, 1, 7'h05, 16'hA55A, 2'b11);
    step();
    idle_bus();
    chk("wr_t1_wren", rf_wren_o, 1);
    chk("wr_t1_addr", rf_addr_o, 7'h05);
    chk("wr_t1_data", rf_data_o, 16'hA55A);
    chk("wr_t1_be", rf_be_o, 2'b11);
    chk("wr_t1_waitreq", avs_waitrequest_o, 1);
    step();
    chk("wr_t2_wren", rf_wren_o, 0);
    chk("wr_t2_waitreq", avs_waitrequest_o, 0);
    chk("wr_t2_addr_hold", rf_addr_o, 7'h05);
    req(1, 0, 7'h41, 16'h0000, 2'b11);
    rf_data_i = 16'h1234;
    step();
    idle_bus();
    chk("rd_t1_waitreq", avs_waitrequest_o, 1);
    chk("rd_t1_rvalid", avs_readdatavalid_o, 0);
    chk("rd_t1_wren", rf_wren_o, 0);
    chk("rd_t1_addr", rf_addr_o, 7'h41);
    step();
    rf_data_i = 16'hFFFF;
    chk("rd_t2_rvalid", avs_readdatavalid_o, 1);
    chk("rd_t2_rdata", avs_readdata_o, 16'h1234);
    chk("rd_t2_waitreq", avs_waitrequest_o, 1);
    step();
    chk("rd_t3_rvalid", avs_readdatavalid_o, 0);
    chk("rd_t3_waitreq", avs_waitrequest_o, 0);
    chk("rd_t3_rdata_hold", avs_readdata_o, 16'h1234);
    req(0, 1, 7'h10, 16'hBEEF, 2'b00);
    step();
    idle_bus();
    chk("be0_t1_wren", rf_wren_o, 0);
    chk("be0_t1_be", rf_be_o, 2'b00);
    chk("be0_t1_waitreq", avs_waitrequest_o, 1);
    step();
    chk("be0_t2_waitreq", avs_waitrequest_o, 0);
    chk("be0_t2_wren", rf_wren_o, 0);
    req(0, 1, 7'h7F, 16'h00C3, 2'b10);
    step();
    idle_bus();
    chk("be2_t1_wren", rf_wren_o, 1);
    chk("be2_t1_be", rf_be_o, 2'b10);
    chk("be2_t1_addr", rf_addr_o, 7'h7F);
    chk("be2_t1_data", rf_data_o, 16'h00C3);
    step();
    chk("pre_both_perr", proto_err_o, 0);
    req(1, 1, 7'h22, 16'h1111, 2'b11);
    step();
    idle_bus();
    chk("both_t1_wren", rf_wren_o, 1);
    chk("both_t1_perr", proto_err_o, 1);
    chk("both_t1_data", rf_data_o, 16'h1111);
    step();
    chk("both_t2_rvalid", avs_readdatavalid_o, 0);
    chk("both_t2_waitreq", avs_waitrequest_o, 0);
    step();
    chk("both_t3_rvalid", avs_readdatavalid_o, 0);
    chk("both_t3_perr_sticky", proto_err_o, 1);
    req(1, 0, 7'h33, 16'h0000, 2'b11);
    rf_data_i = 16'hCAFE;
    step();
    idle_bus();
    chk("rstrd_t1_waitreq", avs_waitrequest_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rstrd_perr_clr", proto_err_o, 0);
    chk("rstrd_waitreq", avs_waitrequest_o, 1);
    chk("rstrd_addr_clr", rf_addr_o, 0);
    step();
    chk("rstrd_rvalid_a", avs_readdatavalid_o, 0);
    rst_i = 1'b0;
    step();
    chk("rstrd_rvalid_b", avs_readdatavalid_o, 0);
    chk("rstrd_rdata", avs_readdata_o, 0);
    step();
    chk("rstrd_rvalid_c", avs_readdatavalid_o, 0);
    chk("rstrd_idle_waitreq", avs_waitrequest_o, 0);
    req(1, 0, 7'h03, 16'h0000, 2'b01);
    rf_data_i = 16'h5A5A;
    step();
    idle_bus();
    step();
    chk("rd2_rvalid", avs_readdatavalid_o, 1);
    chk("rd2_rdata", avs_readdata_o, 16'h5A5A);
    step();
`ifdef AVMM_REGFILE_BRIDGE_STATS_EN
    chk("stats_rd_after_rst", rd_cnt_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    chk("stats_rst_wr", wr_cnt_o, 0);
    chk("stats_rst_rd", rd_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      req(0, 1, 7'(i), 16'h0001, (i == 1) ? 2'b00 : 2'b11);
      step();
      idle_bus();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req(1, 0, 7'(i), 16'h0000, 2'b11);
      step();
      idle_bus();
      step();
      step();
    end
    chk("stats_wr3", wr_cnt_o, 3);
    chk("stats_rd2", rd_cnt_o, 2);
    req(0, 1, 7'h01, 16'h0002, 2'b11);
    stats_clr_i = 1'b1;
    step();
    idle_bus();
    stats_clr_i = 1'b0;
    chk("stats_clr_wr", wr_cnt_o, 0);
    chk("stats_clr_rd", rd_cnt_o, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      req(0, 1, 7'(i), 16'h0003, 2'b01);
      step();
      idle_bus();
      step();
    end
    chk("stats_sat_wr", wr_cnt_o, 3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
